xpsr_write_sched: RTL and testbench

//  Write scheduler/sequencer for the xPSR register block. Arbitrates flag, MSR and IT-instruction updates
//  and runs the exception entry/return sequences that snapshot and restore xPSR. Drives set_data/en_apsr/
//  en_ipsr/en_epsr into xpsr_reg. Gates inst_valid so IT-state advance never coincides with a sequenced write.

---
 rtl/xpsr_write_sched_pkg.sv | 40 ++++
 rtl/xpsr_write_sched_snap_fmt.sv | 23 ++
 rtl/xpsr_write_sched.sv | 146 ++++++++++++++
 tb/tb_xpsr_write_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xpsr_write_sched_pkg.sv
// xPSR field positions and write-scheduler types shared by the scheduler and its
// snapshot formatter.
package xpsr_write_sched_pkg;

   localparam int APSR_HI  = 31;
   localparam int APSR_LO  = 27;
   localparam int IT_LO_HI = 26;
   localparam int IT_LO_LO = 25;
   localparam int T_POS    = 24;
   localparam int ICI_HI   = 15;
   localparam int ICI_LO   = 10;
   localparam int A_POS    = 9;
   localparam int IPSR_HI  = 8;

   localparam logic [4:0] APSR_ALL = 5'b11111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENT_DRAIN,
      ST_ENT_PUSH,
      ST_ENT_SET,
      ST_ENT_DONE,
      ST_RET_WAIT,
      ST_RET_WRITE,
      ST_RET_DONE
   } sched_state_e;

   // One xpsr_reg write: data plus the per-field enables that qualify it.
   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  apsr;
      logic        ipsr;
      logic        epsr;
   } xpsr_wr_t;

   function automatic logic any_write(input xpsr_wr_t wr);
      return (|wr.apsr) | wr.ipsr | wr.epsr;
   endfunction

endpackage

// File: rtl/xpsr_write_sched_snap_fmt.sv
// Packs the APSR/EPSR/IPSR readback fields into the architectural 32-bit xPSR word
// used for the stacked exception frame.
module xpsr_snap_fmt
   import xpsr_write_sched_pkg::*;
(
   input  logic [4:0]  apsr,
   input  logic [9:0]  epsr,
   input  logic [8:0]  ipsr,
   output logic [31:0] xpsr
);

   // EPSR readback is {IT[1:0],T,IT/ICI[7:2],a}; bits 23:16 stay reserved-zero.
   always_comb begin
      xpsr                   = '0;
      xpsr[APSR_HI:APSR_LO]  = apsr;
      xpsr[IT_LO_HI:IT_LO_LO] = epsr[9:8];
      xpsr[T_POS]            = epsr[7];
      xpsr[ICI_HI:ICI_LO]    = epsr[6:1];
      xpsr[A_POS]            = epsr[0];
      xpsr[IPSR_HI:0]        = ipsr;
   end

endmodule

// File: rtl/xpsr_write_sched.sv
// Arbitrates flag/MSR/IT updates into xpsr_reg and sequences exception entry
// (snapshot push + IPSR/EPSR load) and exception return (unstacked restore).
module xpsr_write_sched
   import xpsr_write_sched_pkg::*;
#(
   parameter logic RESET_T = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  xpsr_apsr,
   input  logic [8:0]  xpsr_ipsr,
   input  logic [9:0]  xpsr_epsr,
   input  logic        alu_vld,
   output logic        alu_rdy,
   input  logic [4:0]  alu_mask,
   input  logic [4:0]  alu_flags,
   input  logic        msr_vld,
   output logic        msr_rdy,
   input  logic [4:0]  msr_data,
   input  logic        it_vld,
   output logic        it_rdy,
   input  logic [7:0]  it_state,
   input  logic        exc_ent_req,
   input  logic [8:0]  exc_num,
   input  logic        stk_align,
   input  logic        exc_ret_req,
   output logic        exc_ack,
   output logic [31:0] stk_xpsr,
   output logic        stk_vld,
   input  logic        stk_rdy,
   input  logic [31:0] ustk_xpsr,
   input  logic        ustk_vld,
   input  logic        inst_valid_in,
   output logic        inst_valid_out,
   output logic [31:0] set_data,
   output logic [4:0]  en_apsr,
   output logic        en_ipsr,
   output logic        en_epsr,
   output logic        busy
);

   sched_state_e state_q, state_d;
   xpsr_wr_t     wr_q, wr_d;
   logic [31:0]  snap_q, snap_d, snap_fmt;
   logic [8:0]   exc_num_q, exc_num_d;
   logic         inst_valid_out_q, inst_valid_out_d;
   logic         idle, grant_free;

   xpsr_snap_fmt u_snap_fmt (
      .apsr (xpsr_apsr),
      .epsr (xpsr_epsr),
      .ipsr (xpsr_ipsr),
      .xpsr (snap_fmt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         wr_q             <= '0;
         snap_q           <= '0;
         exc_num_q        <= '0;
         inst_valid_out_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         wr_q             <= wr_d;
         snap_q           <= snap_d;
         exc_num_q        <= exc_num_d;
         inst_valid_out_q <= inst_valid_out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (exc_ent_req)      state_d = ST_ENT_DRAIN;
            else if (exc_ret_req) state_d = ST_RET_WAIT;
         end
         ST_ENT_DRAIN: state_d = ST_ENT_PUSH;
         ST_ENT_PUSH:  if (stk_rdy) state_d = ST_ENT_SET;
         ST_ENT_SET:   state_d = ST_ENT_DONE;
         ST_ENT_DONE:  state_d = ST_IDLE;
         ST_RET_WAIT:  if (ustk_vld) state_d = ST_RET_WRITE;
         ST_RET_WRITE: state_d = ST_RET_DONE;
         ST_RET_DONE:  state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   assign idle       = (state_q == ST_IDLE);
   assign grant_free = idle & ~rst & ~exc_ent_req & ~exc_ret_req;

   // Fixed priority among ordinary writers: MSR > IT > ALU; exceptions block all.
   always_comb begin
      msr_rdy = grant_free & msr_vld;
      it_rdy  = grant_free & it_vld & ~msr_vld;
      alu_rdy = grant_free & alu_vld & ~msr_vld & ~it_vld;
      stk_vld = (state_q == ST_ENT_PUSH);
      exc_ack = (state_q == ST_ENT_DONE) | (state_q == ST_RET_DONE);
      busy    = ~idle;
   end

   // The drain cycle lets the last ordinary write land before the snapshot is taken.
   always_comb begin
      wr_d      = '0;
      snap_d    = snap_q;
      exc_num_d = exc_num_q;
      if (idle && exc_ent_req) exc_num_d = exc_num;
      if (state_q == ST_ENT_DRAIN) begin
         snap_d        = snap_fmt;
         snap_d[A_POS] = stk_align;
      end
      if (msr_rdy) begin
         wr_d.apsr                  = APSR_ALL;
         wr_d.data[APSR_HI:APSR_LO] = msr_data;
      end else if (it_rdy) begin
         wr_d.epsr                    = 1'b1;
         wr_d.data[IT_LO_HI:IT_LO_LO] = it_state[1:0];
         wr_d.data[ICI_HI:ICI_LO]     = it_state[7:2];
         wr_d.data[T_POS]             = xpsr_epsr[7];
         wr_d.data[A_POS]             = xpsr_epsr[0];
      end else if (alu_rdy && (alu_mask != 5'b00000)) begin
         wr_d.apsr                  = alu_mask;
         wr_d.data[APSR_HI:APSR_LO] = alu_flags;
      end else if ((state_q == ST_ENT_PUSH) && stk_rdy) begin
         wr_d.ipsr            = 1'b1;
         wr_d.epsr            = 1'b1;
         wr_d.data[IPSR_HI:0] = exc_num_q;
         wr_d.data[T_POS]     = RESET_T;
      end else if ((state_q == ST_RET_WAIT) && ustk_vld) begin
         wr_d.apsr = APSR_ALL;
         wr_d.ipsr = 1'b1;
         wr_d.epsr = 1'b1;
         wr_d.data = ustk_xpsr;
      end
      inst_valid_out_d = inst_valid_in & idle & ~any_write(wr_d);
   end

   assign set_data       = wr_q.data;
   assign en_apsr        = wr_q.apsr;
   assign en_ipsr        = wr_q.ipsr;
   assign en_epsr        = wr_q.epsr;
   assign stk_xpsr       = snap_q;
   assign inst_valid_out = inst_valid_out_q;

endmodule

// File: tb/tb_xpsr_write_sched.sv
// Directed bench for xpsr_write_sched: a cycle-level reference model checked every
// cycle, plus hand-computed literal expectations at key points.
`timescale 1ns/1ps
module tb_xpsr_write_sched;

   localparam logic       RESET_T_TB  = 1'b1;
   localparam logic [1:0] MODE_IDLE   = 2'd0;
   localparam logic [1:0] MODE_ENTRY  = 2'd1;
   localparam logic [1:0] MODE_RETURN = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  xpsr_apsr;
   logic [8:0]  xpsr_ipsr;
   logic [9:0]  xpsr_epsr;
   logic        alu_vld, alu_rdy;
   logic [4:0]  alu_mask, alu_flags;
   logic        msr_vld, msr_rdy;
   logic [4:0]  msr_data;
   logic        it_vld, it_rdy;
   logic [7:0]  it_state;
   logic        exc_ent_req, stk_align, exc_ret_req, exc_ack;
   logic [8:0]  exc_num;
   logic [31:0] stk_xpsr, ustk_xpsr, set_data;
   logic        stk_vld, stk_rdy, ustk_vld;
   logic        inst_valid_in, inst_valid_out;
   logic [4:0]  en_apsr;
   logic        en_ipsr, en_epsr, busy;

   int nvec  = 0;
   int nfail = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   xpsr_write_sched #(.RESET_T(RESET_T_TB)) dut (
      .clk(clk), .rst(rst),
      .xpsr_apsr(xpsr_apsr), .xpsr_ipsr(xpsr_ipsr), .xpsr_epsr(xpsr_epsr),
      .alu_vld(alu_vld), .alu_rdy(alu_rdy), .alu_mask(alu_mask), .alu_flags(alu_flags),
      .msr_vld(msr_vld), .msr_rdy(msr_rdy), .msr_data(msr_data),
      .it_vld(it_vld), .it_rdy(it_rdy), .it_state(it_state),
      .exc_ent_req(exc_ent_req), .exc_num(exc_num), .stk_align(stk_align),
      .exc_ret_req(exc_ret_req), .exc_ack(exc_ack),
      .stk_xpsr(stk_xpsr), .stk_vld(stk_vld), .stk_rdy(stk_rdy),
      .ustk_xpsr(ustk_xpsr), .ustk_vld(ustk_vld),
      .inst_valid_in(inst_valid_in), .inst_valid_out(inst_valid_out),
      .set_data(set_data), .en_apsr(en_apsr), .en_ipsr(en_ipsr), .en_epsr(en_epsr),
      .busy(busy)
   );

   typedef struct packed {
      logic [1:0]  mode;
      logic [1:0]  step;
      logic [31:0] data;
      logic [4:0]  en_apsr;
      logic        en_ipsr;
      logic        en_epsr;
      logic        ivo;
      logic [31:0] snap;
      logic [8:0]  num;
   } model_t;

   model_t m = '0;

   function automatic logic [31:0] composeXpsr(input logic [4:0] a, input logic [9:0] e,
                                               input logic [8:0] i);
      return (32'(a) << 27) | (32'(e[9:8]) << 25) | (32'(e[7]) << 24) |
             (32'(e[6:1]) << 10) | (32'(e[0]) << 9) | 32'(i);
   endfunction

   // The model advances one clock from the inputs as they stood before the edge.
   function automatic model_t modelStep(input model_t cur);
      model_t nx;
      logic   wrote;
      nx         = cur;
      nx.data    = '0;
      nx.en_apsr = '0;
      nx.en_ipsr = 1'b0;
      nx.en_epsr = 1'b0;
      nx.ivo     = 1'b0;
      if (rst) begin
         nx.mode = MODE_IDLE;
         nx.step = 2'd0;
         return nx;
      end
      case (cur.mode)
         MODE_IDLE: begin
            if (exc_ent_req) begin
               nx.mode = MODE_ENTRY; nx.step = 2'd0; nx.num = exc_num;
            end else if (exc_ret_req) begin
               nx.mode = MODE_RETURN; nx.step = 2'd0;
            end else if (msr_vld) begin
               nx.en_apsr = 5'b11111; nx.data = {msr_data, 27'd0};
            end else if (it_vld) begin
               nx.en_epsr = 1'b1;
               nx.data = composeXpsr(5'd0, {it_state[1:0], xpsr_epsr[7], it_state[7:2],
                                            xpsr_epsr[0]}, 9'd0);
            end else if (alu_vld && alu_mask != 5'd0) begin
               nx.en_apsr = alu_mask; nx.data = {alu_flags, 27'd0};
            end
         end
         MODE_ENTRY: begin
            if (cur.step == 2'd0) begin
               nx.snap = composeXpsr(xpsr_apsr, xpsr_epsr, xpsr_ipsr);
               nx.snap[9] = stk_align;
               nx.step = 2'd1;
            end else if (cur.step == 2'd1) begin
               if (stk_rdy) begin
                  nx.en_ipsr = 1'b1; nx.en_epsr = 1'b1;
                  nx.data = composeXpsr(5'd0, {2'b00, RESET_T_TB, 6'd0, 1'b0}, cur.num);
                  nx.step = 2'd2;
               end
            end else if (cur.step == 2'd2) begin
               nx.step = 2'd3;
            end else begin
               nx.mode = MODE_IDLE;
            end
         end
         MODE_RETURN: begin
            if (cur.step == 2'd0) begin
               if (ustk_vld) begin
                  nx.en_apsr = 5'b11111; nx.en_ipsr = 1'b1; nx.en_epsr = 1'b1;
                  nx.data = ustk_xpsr;
                  nx.step = 2'd1;
               end
            end else if (cur.step == 2'd1) begin
               nx.step = 2'd2;
            end else begin
               nx.mode = MODE_IDLE;
            end
         end
         default: nx.mode = MODE_IDLE;
      endcase
      wrote  = (nx.en_apsr != 5'd0) || nx.en_ipsr || nx.en_epsr;
      nx.ivo = inst_valid_in && (cur.mode == MODE_IDLE) && !wrote;
      return nx;
   endfunction

   always @(posedge clk) m <= modelStep(m);

   function automatic logic [2:0] expRdy();
      logic free;
      free = (m.mode == MODE_IDLE) && !rst && !exc_ent_req && !exc_ret_req;
      return {free && msr_vld, free && it_vld && !msr_vld,
              free && alu_vld && !msr_vld && !it_vld};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      nvec++;
      nfail++;
      $display("[TB] FAIL %s: got no event within budget, expected one at %0t", name, $time);
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         checkOutput("rdy", 64'({msr_rdy, it_rdy, alu_rdy}), 64'(expRdy()));
         checkOutput("busy", 64'(busy), 64'(m.mode != MODE_IDLE));
         checkOutput("stk_vld", 64'(stk_vld), 64'(m.mode == MODE_ENTRY && m.step == 2'd1));
         checkOutput("exc_ack", 64'(exc_ack), 64'((m.mode == MODE_ENTRY && m.step == 2'd3) ||
                                                  (m.mode == MODE_RETURN && m.step == 2'd2)));
         checkOutput("set_data", 64'(set_data), 64'(m.data));
         checkOutput("en_apsr", 64'(en_apsr), 64'(m.en_apsr));
         checkOutput("en_ipsr", 64'(en_ipsr), 64'(m.en_ipsr));
         checkOutput("en_epsr", 64'(en_epsr), 64'(m.en_epsr));
         checkOutput("inst_valid_out", 64'(inst_valid_out), 64'(m.ivo));
         if (m.mode == MODE_ENTRY && m.step == 2'd1)
            checkOutput("stk_xpsr", 64'(stk_xpsr), 64'(m.snap));
      end
   end

   task automatic waitForStkVld();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (stk_vld) seen = 1'b1;
      end
      if (!seen) timeoutFail("wait_stk_vld");
   endtask

   task automatic waitForAck(output int pushes);
      logic seen;
      seen   = 1'b0;
      pushes = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (stk_vld) pushes++;
         if (exc_ack) seen = 1'b1;
      end
      if (!seen) timeoutFail("wait_exc_ack");
   endtask

   initial begin
      int pushes;
      rst = 1'b1;
      xpsr_apsr = 5'b01010; xpsr_ipsr = 9'd3; xpsr_epsr = 10'b10_1_011010_1;
      alu_vld = 0; alu_mask = 0; alu_flags = 0; msr_vld = 0; msr_data = 0;
      it_vld = 0; it_state = 0; exc_ent_req = 0; exc_num = 0; stk_align = 0;
      exc_ret_req = 0; stk_rdy = 0; ustk_xpsr = 0; ustk_vld = 0; inst_valid_in = 1;

      @(posedge clk); #1; cmp_en = 1'b1;
      msr_vld = 1'b1;
      applyStimulus();
      @(negedge clk);
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_msr_rdy", 64'(msr_rdy), 64'(0));
      checkOutput("rst_en_apsr", 64'(en_apsr), 64'(0));
      checkOutput("rst_ivo", 64'(inst_valid_out), 64'(0));
      applyStimulus(); rst = 1'b0; msr_vld = 1'b0;

      // ALU partial-flag write lands exactly one cycle after acceptance.
      alu_vld = 1; alu_mask = 5'b11000; alu_flags = 5'b10101;
      @(negedge clk); checkOutput("alu_rdy_lit", 64'(alu_rdy), 64'(1));
      applyStimulus(); alu_vld = 0;
      @(negedge clk);
      checkOutput("alu_en_lit", 64'(en_apsr), 64'(5'b11000));
      checkOutput("alu_nz_lit", 64'(set_data[31:30]), 64'(2'b10));
      checkOutput("ivo_wr_lit", 64'(inst_valid_out), 64'(0));
      applyStimulus();
      @(negedge clk);
      checkOutput("alu_once_lit", 64'(en_apsr), 64'(0));
      checkOutput("ivo_idle_lit", 64'(inst_valid_out), 64'(1));

      applyStimulus(); alu_vld = 1; alu_mask = 5'b00000; alu_flags = 5'b11111; inst_valid_in = 0;
      @(negedge clk); checkOutput("alu0_rdy_lit", 64'(alu_rdy), 64'(1));
      applyStimulus(); alu_vld = 0; inst_valid_in = 1;
      @(negedge clk); checkOutput("alu0_nowr_lit", 64'(en_apsr), 64'(0));

      // Three simultaneous requesters drain in priority order.
      applyStimulus();
      msr_vld = 1; msr_data = 5'b11011; it_vld = 1; it_state = 8'hA5;
      alu_vld = 1; alu_mask = 5'b00111; alu_flags = 5'b00001;
      @(negedge clk); checkOutput("prio_msr_lit", 64'({msr_rdy, it_rdy, alu_rdy}), 64'(3'b100));
      applyStimulus(); msr_vld = 0;
      @(negedge clk);
      checkOutput("prio_it_lit", 64'({msr_rdy, it_rdy, alu_rdy}), 64'(3'b010));
      checkOutput("msr_data_lit", 64'(set_data), 64'(32'hD800_0000));
      applyStimulus(); it_vld = 0;
      @(negedge clk);
      checkOutput("prio_alu_lit", 64'({msr_rdy, it_rdy, alu_rdy}), 64'(3'b001));
      checkOutput("it_data_lit", 64'(set_data), 64'(32'h0300_A600));
      applyStimulus(); alu_vld = 0;
      @(negedge clk); checkOutput("alu2_data_lit", 64'(set_data), 64'(32'h0800_0000));

      // Entry with stack push back-pressured for three cycles.
      applyStimulus(); exc_ent_req = 1; exc_num = 9'd15; stk_align = 0; stk_rdy = 0;
      waitForStkVld();
      checkOutput("snap_lit", 64'(stk_xpsr), 64'(32'h5500_6803));
      for (int i = 0; i < 2; i++) begin
         applyStimulus();
         @(negedge clk);
         checkOutput("push_hold_lit", 64'({stk_vld, stk_xpsr}), 64'({1'b1, 32'h5500_6803}));
      end
      applyStimulus(); stk_rdy = 1;
      @(negedge clk); checkOutput("push_last_lit", 64'(stk_vld), 64'(1));
      applyStimulus(); stk_rdy = 0;
      @(negedge clk);
      checkOutput("ent_data_lit", 64'(set_data), 64'(32'h0100_000F));
      checkOutput("ent_en_lit", 64'({en_apsr, en_ipsr, en_epsr}), 64'(7'b00000_11));
      checkOutput("ent_ivo_lit", 64'(inst_valid_out), 64'(0));
      applyStimulus();
      @(negedge clk); checkOutput("ent_ack_lit", 64'(exc_ack), 64'(1));
      applyStimulus(); exc_ent_req = 0;
      @(negedge clk); checkOutput("ent_ack_once_lit", 64'(exc_ack), 64'(0));

      // Unstacked word outside a return is ignored; then a real return.
      applyStimulus(); ustk_vld = 1; ustk_xpsr = 32'hDEAD_BEEF;
      applyStimulus(); ustk_vld = 0; exc_ret_req = 1; ustk_xpsr = 32'hF100_0C03;
      @(negedge clk); checkOutput("ustk_ignored_lit", 64'(en_ipsr), 64'(0));
      repeat (4) applyStimulus();
      ustk_vld = 1;
      applyStimulus(); ustk_vld = 0;
      @(negedge clk);
      checkOutput("ret_data_lit", 64'(set_data), 64'(32'hF100_0C03));
      checkOutput("ret_en_lit", 64'({en_apsr, en_ipsr, en_epsr}), 64'(7'b11111_11));
      checkOutput("ret_ivo_lit", 64'(inst_valid_out), 64'(0));
      waitForAck(pushes);
      applyStimulus(); exc_ret_req = 0;
      @(negedge clk); checkOutput("ret_ack_once_lit", 64'(exc_ack), 64'(0));

      // Both exception requests with an always-ready stacker: entry, then return.
      applyStimulus(); exc_ent_req = 1; exc_ret_req = 1; exc_num = 9'd11; stk_rdy = 1;
      stk_align = 1; ustk_xpsr = 32'h2000_0005;
      waitForAck(pushes);
      checkOutput("single_push_lit", 64'(pushes), 64'(1));
      applyStimulus(); exc_ent_req = 0;
      repeat (3) applyStimulus();
      ustk_vld = 1;
      applyStimulus(); ustk_vld = 0;
      waitForAck(pushes);
      applyStimulus(); exc_ret_req = 0;

      // Entry request dropped after one cycle still completes with the captured number.
      applyStimulus(); exc_ent_req = 1; exc_num = 9'd5;
      applyStimulus(); exc_ent_req = 0; exc_num = 9'd77;
      waitForAck(pushes);

      // Reset during the push abandons the sequence cleanly.
      applyStimulus(); exc_ent_req = 1; exc_num = 9'd21; stk_rdy = 0;
      waitForStkVld();
      applyStimulus(); rst = 1; exc_ent_req = 0;
      applyStimulus(); rst = 0;
      @(negedge clk);
      checkOutput("rst_seq_lit", 64'({busy, stk_vld, exc_ack, en_apsr, en_ipsr, en_epsr}),
                  64'(10'd0));
      applyStimulus(); msr_vld = 1; msr_data = 5'b00110;
      @(negedge clk); checkOutput("post_rst_rdy_lit", 64'(msr_rdy), 64'(1));
      applyStimulus(); msr_vld = 0;
      @(negedge clk); checkOutput("post_rst_data_lit", 64'(set_data), 64'(32'h3000_0000));
      repeat (3) applyStimulus();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
